// File: rtl/mem_arbiter_if.sv
// Handshake bundle for mem_arbiter: fetch port, data port and the shared
// single-port memory bus. The arbiter uses "master"; its environment uses "slave".
interface mem_arbiter_if;
  logic        ireq;
  logic [31:0] iaddr;
  logic        ivalid;
  logic [31:0] irdata;
  logic        istall;

  logic        dreq;
  logic        dwe;
  logic        dbyte;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic        dvalid;
  logic [31:0] drdata;
  logic        dstall;

  logic        mem_req;
  logic        mem_we;
  logic        mem_byte;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  logic        err;

  modport master (
    input  ireq, iaddr, dreq, dwe, dbyte, daddr, dwdata, mem_ready, mem_rdata,
    output ivalid, irdata, istall, dvalid, drdata, dstall,
    output mem_req, mem_we, mem_byte, mem_addr, mem_wdata, err
  );

  modport slave (
    output ireq, iaddr, dreq, dwe, dbyte, daddr, dwdata, mem_ready, mem_rdata,
    input  ivalid, irdata, istall, dvalid, drdata, dstall,
    input  mem_req, mem_we, mem_byte, mem_addr, mem_wdata, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / data) arbiter for one single-port memory, with a wait
// timeout and sticky err flag. Define ARB_RR_EN for round-robin; default is D-over-I.
module mem_arbiter #(
  parameter int MAX_WAIT = 15
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, IBUSY, DBUSY, DONE} state_t;

  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  state_t      state;
  logic        mem_req_r;
  logic        mem_we_r;
  logic        mem_byte_r;
  logic [31:0] mem_addr_r;
  logic [31:0] mem_wdata_r;
  logic        ivalid_r;
  logic        dvalid_r;
  logic [31:0] irdata_r;
  logic [31:0] drdata_r;
  logic        err_r;
  logic [7:0]  wait_cnt;
  logic        grant_d;
  logic        grant_i;

`ifdef ARB_RR_EN
  logic last_d;  // 1 when the most recent grant went to D

  always_comb begin
    grant_d = bus.dreq && (!bus.ireq || !last_d);
  end
`else
  always_comb begin
    grant_d = bus.dreq;
  end
`endif

  assign grant_i = bus.ireq && !grant_d;

  // NOTE: state and outputs are updated with <= so every branch sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_byte_r  <= 1'b0;
      mem_addr_r  <= 32'h0;
      mem_wdata_r <= 32'h0;
      ivalid_r    <= 1'b0;
      dvalid_r    <= 1'b0;
      irdata_r    <= 32'h0;
      drdata_r    <= 32'h0;
      err_r       <= 1'b0;
      wait_cnt    <= 8'h0;
`ifdef ARB_RR_EN
      last_d      <= 1'b0;
`endif
    end else begin
      ivalid_r <= 1'b0;
      dvalid_r <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            mem_req_r   <= 1'b1;
            mem_we_r    <= bus.dwe;
            mem_byte_r  <= bus.dbyte;
            mem_addr_r  <= bus.daddr;
            mem_wdata_r <= bus.dwdata;
            wait_cnt    <= 8'h0;
            state       <= DBUSY;
`ifdef ARB_RR_EN
            last_d      <= 1'b1;
`endif
          end else if (grant_i) begin
            mem_req_r   <= 1'b1;
            mem_we_r    <= 1'b0;
            mem_byte_r  <= 1'b0;
            mem_addr_r  <= bus.iaddr;
            wait_cnt    <= 8'h0;
            state       <= IBUSY;
`ifdef ARB_RR_EN
            last_d      <= 1'b0;
`endif
          end
        end
        IBUSY, DBUSY: begin
          // A ready memory wins over the timeout in the same cycle; an abort
          // returns zero data but still completes with a valid pulse.
          if (bus.mem_ready || wait_cnt == WAIT_LIMIT) begin
            mem_req_r <= 1'b0;
            state     <= DONE;
            if (!bus.mem_ready) err_r <= 1'b1;
            if (state == IBUSY) begin
              ivalid_r <= 1'b1;
              irdata_r <= bus.mem_ready ? bus.mem_rdata : 32'h0;
            end else begin
              dvalid_r <= 1'b1;
              // Stores never touch the load-data register.
              if (!mem_we_r) drdata_r <= bus.mem_ready ? bus.mem_rdata : 32'h0;
            end
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_req   = mem_req_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_byte  = mem_byte_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.ivalid    = ivalid_r;
  assign bus.dvalid    = dvalid_r;
  assign bus.irdata    = irdata_r;
  assign bus.drdata    = drdata_r;
  assign bus.err       = err_r;
  assign bus.istall    = bus.ireq && !ivalid_r;
  assign bus.dstall    = bus.dreq && !dvalid_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a transaction-timeline model (grant, bus cycles, valid
// cycle) checked every cycle, directed literal scenarios, then random traffic.
module tb_mem_arbiter;
  localparam int MW = 4;
`ifdef ARB_RR_EN
  localparam logic [3:0] EXP_ORDER = 4'b1010;
`else
  localparam logic [3:0] EXP_ORDER = 4'b1111;
`endif

  logic clk = 1'b0;
  logic reset;
  mem_arbiter_if bus();

  mem_arbiter #(.MAX_WAIT(MW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h, time %0t", name, act, exp, $time);
    end
  endtask

  // Model: ph = 0 free, 1..blen memory cycles of the current transaction,
  // blen+1 the valid cycle. Memory timing is planned at grant time.
  int          ph, blen, w_cur;
  bit          cur_d;
  logic [31:0] rd_cur, m_addr, m_wdata, m_irdata, m_drdata;
  logic        m_we, m_byte, m_err;
  bit          d_done, i_done;
`ifdef ARB_RR_EN
  bit          m_last_d;
`endif
  bit          force_en, cmp_en;
  int          force_w;
  logic [31:0] force_rd;
  bit          m_busy, m_vi, m_vd;

  task automatic model_reset();
    ph = 0; blen = 0; w_cur = 0; cur_d = 0; rd_cur = 0;
    m_addr = 0; m_wdata = 0; m_irdata = 0; m_drdata = 0;
    m_we = 0; m_byte = 0; m_err = 0; d_done = 0; i_done = 0;
`ifdef ARB_RR_EN
    m_last_d = 0;
`endif
  endtask

  task automatic model_update();
    bit take_d;
    d_done = 0;
    i_done = 0;
    if (ph == 0) begin
`ifdef ARB_RR_EN
      take_d = (bus.dreq && bus.ireq) ? !m_last_d : bus.dreq;
`else
      take_d = bus.dreq;
`endif
      if (bus.dreq || bus.ireq) begin
        cur_d = take_d;
        ph = 1;
        if (take_d) begin
          m_we = bus.dwe; m_byte = bus.dbyte; m_addr = bus.daddr; m_wdata = bus.dwdata;
        end else begin
          m_we = 0; m_byte = 0; m_addr = bus.iaddr;
        end
`ifdef ARB_RR_EN
        m_last_d = take_d;
`endif
        w_cur = force_en ? force_w : int'($urandom_range(0, MW + 2));
        if (m_we && w_cur > MW) w_cur = int'($urandom_range(0, MW));
        rd_cur = force_en ? force_rd : $urandom;
        blen = (w_cur > MW ? MW : w_cur) + 1;
      end
    end else if (ph <= blen) begin
      ph++;
      if (ph == blen + 1) begin
        if (w_cur > MW) begin
          m_err = 1;
          if (!cur_d) m_irdata = 0;
          else if (!m_we) m_drdata = 0;
        end else if (!cur_d) begin
          m_irdata = rd_cur;
        end else if (!m_we) begin
          m_drdata = rd_cur;
        end
      end
    end else begin
      ph = 0;
      d_done = cur_d;
      i_done = !cur_d;
    end
  endtask

  task automatic drive_mem();
    if (ph >= 1 && ph <= blen) begin
      bus.mem_ready = (ph > w_cur);
      bus.mem_rdata = (ph == blen && ph > w_cur) ? rd_cur : $urandom;
    end else begin
      bus.mem_ready = 1'($urandom);
      bus.mem_rdata = $urandom;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_update();
    drive_mem();
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      m_busy = (ph >= 1 && ph <= blen);
      m_vi   = (ph == blen + 1) && !cur_d;
      m_vd   = (ph == blen + 1) && cur_d;
      check("mem_req", 32'(bus.mem_req), 32'(m_busy));
      check("ivalid", 32'(bus.ivalid), 32'(m_vi));
      check("dvalid", 32'(bus.dvalid), 32'(m_vd));
      check("irdata", bus.irdata, m_irdata);
      check("drdata", bus.drdata, m_drdata);
      check("err", 32'(bus.err), 32'(m_err));
      check("istall", 32'(bus.istall), 32'(bus.ireq && !m_vi));
      check("dstall", 32'(bus.dstall), 32'(bus.dreq && !m_vd));
      if (m_busy) begin
        check("mem_addr", bus.mem_addr, m_addr);
        check("mem_we", 32'(bus.mem_we), 32'(m_we));
        check("mem_byte", 32'(bus.mem_byte), 32'(m_byte));
        if (m_we) check("mem_wdata", bus.mem_wdata, m_wdata);
      end
    end
  end

  // One directed transaction from an idle arbiter; returns memory-request
  // cycles, index of the valid cycle and the data register seen then.
  task automatic txn(input bit is_d, input bit we, input bit byt,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input int w, input logic [31:0] rd,
                     output int rc, output int vk, output logic [31:0] vd);
    bit gv;
    force_en = 1; force_w = w; force_rd = rd;
    if (is_d) begin
      bus.dreq = 1; bus.dwe = we; bus.dbyte = byt; bus.daddr = addr; bus.dwdata = wdata;
    end else begin
      bus.ireq = 1; bus.iaddr = addr;
    end
    rc = 0; vk = -1; vd = 32'hx; gv = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      #1;
      if (bus.mem_req) begin
        rc++;
        check("hold_addr", bus.mem_addr, addr);
        check("hold_we", 32'(bus.mem_we), 32'(we));
        check("hold_byte", 32'(bus.mem_byte), 32'(byt));
        if (we) check("hold_wdata", bus.mem_wdata, wdata);
      end
      if (is_d ? bus.dvalid : bus.ivalid) begin
        gv = 1; vk = k; vd = is_d ? bus.drdata : bus.irdata;
        break;
      end
    end
    check("valid_seen", 32'(gv), 32'd1);
    step();
    bus.dreq = 0;
    bus.ireq = 0;
    force_en = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc, vk, nv, first_v, last_v;
    logic [31:0] vd;
    logic [3:0] seq;
    bit dv_seen;

    bus.ireq = 0; bus.iaddr = 0; bus.dreq = 0; bus.dwe = 0; bus.dbyte = 0;
    bus.daddr = 0; bus.dwdata = 0; bus.mem_ready = 0; bus.mem_rdata = 0;
    force_en = 0; force_w = 0; force_rd = 0; cmp_en = 0;
    reset = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 cmp_en = 1;
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_irdata", bus.irdata, 32'h0);
    check("rst_drdata", bus.drdata, 32'h0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    @(posedge clk);
    #3 reset = 0;
    drive_mem();

    // Lone zero-wait fetch.
    txn(0, 0, 0, 32'h100, 32'h0, 0, 32'hE3A00001, rc, vk, vd);
    check("fetch_req_cycles", 32'(rc), 32'd1);
    check("fetch_valid_at", 32'(vk), 32'd1);
    check("fetch_irdata", vd, 32'hE3A00001);

    // Load with one wait cycle, then a byte store with three.
    txn(1, 0, 0, 32'h40, 32'h0, 1, 32'h5A5A1234, rc, vk, vd);
    check("load_req_cycles", 32'(rc), 32'd2);
    check("load_drdata", vd, 32'h5A5A1234);
    txn(1, 1, 1, 32'h20, 32'hAB, 3, 32'hDEADBEEF, rc, vk, vd);
    check("store_req_cycles", 32'(rc), 32'd4);
    check("store_valid_at", 32'(vk), 32'd4);
    check("store_drdata_kept", vd, 32'h5A5A1234);

    // Memory never ready: abort after MW wait cycles, then a normal fetch.
    txn(1, 0, 0, 32'h300, 32'h0, 100, 32'hFFFF0000, rc, vk, vd);
    check("abort_req_cycles", 32'(rc), 32'd5);
    check("abort_drdata", vd, 32'h0);
    check("abort_err", 32'(bus.err), 32'd1);
    txn(0, 0, 0, 32'h104, 32'h0, 0, 32'h12345678, rc, vk, vd);
    check("post_abort_irdata", vd, 32'h12345678);
    check("post_abort_req_cycles", 32'(rc), 32'd1);
    check("err_sticky", 32'(bus.err), 32'd1);

    // Reset in the middle of a data transaction.
    force_en = 1; force_w = 10; force_rd = 32'h0;
    bus.dreq = 1; bus.dwe = 0; bus.dbyte = 0; bus.daddr = 32'h44;
    step();
    step();
    #2 reset = 1;
    model_reset();
    #1;
    check("rst_mid_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mid_dvalid", 32'(bus.dvalid), 32'd0);
    bus.dreq = 0;
    force_en = 0;
    @(posedge clk);
    @(posedge clk);
    #3 reset = 0;
    check("err_after_release", 32'(bus.err), 32'd0);
    drive_mem();
    dv_seen = 0;
    repeat (4) begin
      step();
      #1;
      if (bus.dvalid) dv_seen = 1;
    end
    check("no_dvalid_after_reset", 32'(dv_seen), 32'd0);

    // Both requesters held continuously with a zero-wait memory.
    force_en = 1; force_w = 0; force_rd = 32'h0BAD0000;
    bus.dreq = 1; bus.dwe = 0; bus.dbyte = 0; bus.daddr = 32'h80;
    bus.ireq = 1; bus.iaddr = 32'h200;
    seq = 0; nv = 0; first_v = 0; last_v = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      #1;
      if (bus.dvalid || bus.ivalid) begin
        seq = {seq[2:0], bus.dvalid};
        if (nv == 0) first_v = k;
        last_v = k;
        nv++;
        if (nv == 4) break;
      end
    end
    check("both_valid_count", 32'(nv), 32'd4);
    check("grant_order", 32'(seq), 32'(EXP_ORDER));
    check("grant_period", 32'(last_v - first_v), 32'd9);
    step();
    bus.dreq = 0;
    bus.ireq = 0;
    force_en = 0;

    // Random traffic; requesters hold req until their valid cycle has passed
    // and scramble their fields while their own transaction is in flight.
    for (int c = 0; c < 3000; c++) begin
      step();
      if (d_done) bus.dreq = 0;
      if (i_done) bus.ireq = 0;
      if (!bus.dreq) begin
        if ($urandom_range(0, 2) == 0) begin
          bus.dreq = 1; bus.dwe = 1'($urandom); bus.dbyte = 1'($urandom);
          bus.daddr = $urandom; bus.dwdata = $urandom;
        end
      end else if (cur_d && ph >= 1) begin
        bus.dwe = 1'($urandom); bus.dbyte = 1'($urandom);
        bus.daddr = $urandom; bus.dwdata = $urandom;
      end
      if (!bus.ireq) begin
        if ($urandom_range(0, 2) == 0) begin
          bus.ireq = 1; bus.iaddr = $urandom;
        end
      end else if (!cur_d && ph >= 1) begin
        bus.iaddr = $urandom;
      end
    end

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
